// File: rtl/sbqm_queue_ctrl_if.sv
// rtl/sbqm_queue_ctrl_if.sv - waiting-time ROM address/data bus between queue controller and ROM
interface sbqm_queue_ctrl_if #(parameter int N = 3);
  logic [1:0]   rom_tcount;
  logic [N-1:0] rom_pcount;
  logic [4:0]   rom_wcount;

  modport master (output rom_tcount, output rom_pcount, input rom_wcount);
  modport slave  (input rom_tcount, input rom_pcount, output rom_wcount);
endinterface

// File: rtl/sbqm_queue_ctrl.sv
// rtl/sbqm_queue_ctrl.sv - bank queue counter, teller count and waiting-time ROM lookup sequencer
module sbqm_queue_ctrl #(
  parameter int N = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               front_sensor,
  input  logic               back_sensor,
  input  logic [1:0]         tcount_in,
  input  logic               tcount_load,
  sbqm_queue_ctrl_if.master  rom,
  output logic [N-1:0]       pcount,
  output logic [1:0]         tcount,
  output logic [4:0]         wcount,
  output logic               wcount_valid,
  output logic               full,
  output logic               empty
);

  localparam logic [N-1:0] MAXP = '1;
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, REQ, CAP} state_t;

  state_t       state, state_next;
  logic [2:0]   front_sync, back_sync;
  logic         entry_evt, exit_evt;
  logic [N-1:0] pcount_next;
  logic [1:0]   tcount_next;
  logic         changed, dirty, start, capture;

  assign entry_evt = front_sync[1] & ~front_sync[2];
  assign exit_evt  = back_sync[1] & ~back_sync[2];
  assign full      = (pcount == MAXP);
  assign empty     = (pcount == '0);

  // Saturating occupancy update; simultaneous events cancel except at the rails.
  always_comb begin
    pcount_next = pcount;
    case ({entry_evt, exit_evt})
      2'b10: if (!full) pcount_next = pcount + ONE;
      2'b01: if (!empty) pcount_next = pcount - ONE;
      2'b11: begin
        if (empty) pcount_next = ONE;
        else if (full) pcount_next = pcount - ONE;
      end
      default: ;
    endcase
  end

  assign tcount_next = (tcount_load && tcount_in != 2'd0) ? tcount_in : tcount;
  assign changed     = (pcount_next != pcount) || (tcount_next != tcount);

  always_comb begin
    state_next = state;
    start      = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: if (dirty) begin
        state_next = REQ;
        start      = 1'b1;
      end
      REQ: state_next = CAP;
      CAP: begin
        state_next = IDLE;
        capture    = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_sync     <= '0;
      back_sync      <= '0;
      pcount         <= '0;
      tcount         <= 2'd1;
      dirty          <= 1'b1;
      rom.rom_tcount <= 2'd1;
      rom.rom_pcount <= '0;
      wcount         <= '0;
      wcount_valid   <= 1'b0;
    end else begin
      front_sync <= {front_sync[1:0], front_sensor};
      back_sync  <= {back_sync[1:0], back_sensor};
      pcount     <= pcount_next;
      tcount     <= tcount_next;
      // A change on the same edge as the snapshot keeps dirty so the stale lookup is redone.
      if (changed)    dirty <= 1'b1;
      else if (start) dirty <= 1'b0;
      if (start) begin
        rom.rom_tcount <= tcount;
        rom.rom_pcount <= pcount;
      end
      if (capture) wcount <= rom.rom_wcount;
      if (changed)      wcount_valid <= 1'b0;
      else if (capture) wcount_valid <= ~dirty;
    end
  end

endmodule

// File: tb/tb_sbqm_queue_ctrl.sv
// tb/tb_sbqm_queue_ctrl.sv - self-checking bench for sbqm_queue_ctrl
module tb_sbqm_queue_ctrl;
  localparam int N = 3;
  localparam int MAXP = 7;
  localparam int OP_E = 0, OP_X = 1, OP_B = 2, OP_L = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       front_sensor = 1'b0;
  logic       back_sensor = 1'b0;
  logic [1:0] tcount_in = 2'd0;
  logic       tcount_load = 1'b0;
  logic [N-1:0] pcount;
  logic [1:0] tcount;
  logic [4:0] wcount;
  logic       wcount_valid, full, empty;

  int checks = 0;
  int errors = 0;

  sbqm_queue_ctrl_if #(.N(N)) rom_if ();

  sbqm_queue_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .front_sensor(front_sensor), .back_sensor(back_sensor),
    .tcount_in(tcount_in), .tcount_load(tcount_load),
    .rom(rom_if.master),
    .pcount(pcount), .tcount(tcount), .wcount(wcount),
    .wcount_valid(wcount_valid), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic int wait_time(input int t, input int p);
    if (t == 0) return 0;
    return (3 * (p + t - 1)) / t;
  endfunction

  // Waiting-time ROM: one-cycle registered read.
  always @(posedge clk)
    rom_if.rom_wcount <= 5'(wait_time(int'(rom_if.rom_tcount), int'(rom_if.rom_pcount)));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int p, input int t, input int w);
    check({tag, " pcount"}, int'(pcount), p);
    check({tag, " tcount"}, int'(tcount), t);
    check({tag, " wcount"}, int'(wcount), w);
    check({tag, " valid"}, int'(wcount_valid), 1);
    check({tag, " full"}, int'(full), int'(p == MAXP));
    check({tag, " empty"}, int'(empty), int'(p == 0));
  endtask

  task automatic do_op(input int op, input int arg, output bit dropped);
    dropped = 1'b0;
    case (op)
      OP_E: front_sensor = 1'b1;
      OP_X: back_sensor = 1'b1;
      OP_B: begin front_sensor = 1'b1; back_sensor = 1'b1; end
      default: begin tcount_load = 1'b1; tcount_in = 2'(arg); end
    endcase
    tick();
    tcount_load = 1'b0;
    tick();
    front_sensor = 1'b0;
    back_sensor = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!wcount_valid) dropped = 1'b1;
    end
  endtask

  typedef struct {
    int op;
    int arg;
    int p;
    int t;
    int w;
    bit nochg;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit dropped;
    int mp, mt, op, arg;

    tbl.push_back('{OP_E, 0, 1, 1, 3, 1'b0});
    tbl.push_back('{OP_E, 0, 2, 1, 6, 1'b0});
    tbl.push_back('{OP_E, 0, 3, 1, 9, 1'b0});
    tbl.push_back('{OP_L, 3, 3, 3, 5, 1'b0});
    tbl.push_back('{OP_L, 0, 3, 3, 5, 1'b1});
    tbl.push_back('{OP_L, 3, 3, 3, 5, 1'b1});
    tbl.push_back('{OP_L, 2, 3, 2, 6, 1'b0});
    tbl.push_back('{OP_E, 0, 4, 2, 7, 1'b0});
    tbl.push_back('{OP_E, 0, 5, 2, 9, 1'b0});
    tbl.push_back('{OP_E, 0, 6, 2, 10, 1'b0});
    tbl.push_back('{OP_E, 0, 7, 2, 12, 1'b0});
    tbl.push_back('{OP_E, 0, 7, 2, 12, 1'b1});
    tbl.push_back('{OP_B, 0, 6, 2, 10, 1'b0});
    tbl.push_back('{OP_X, 0, 5, 2, 9, 1'b0});
    tbl.push_back('{OP_X, 0, 4, 2, 7, 1'b0});
    tbl.push_back('{OP_B, 0, 4, 2, 7, 1'b1});
    tbl.push_back('{OP_X, 0, 3, 2, 6, 1'b0});
    tbl.push_back('{OP_X, 0, 2, 2, 4, 1'b0});
    tbl.push_back('{OP_X, 0, 1, 2, 3, 1'b0});
    tbl.push_back('{OP_X, 0, 0, 2, 1, 1'b0});
    tbl.push_back('{OP_X, 0, 0, 2, 1, 1'b1});
    tbl.push_back('{OP_B, 0, 1, 2, 3, 1'b0});
    tbl.push_back('{OP_L, 1, 1, 1, 3, 1'b0});

    // Reset values and post-reset lookup
    tick(); tick();
    check("rst pcount", int'(pcount), 0);
    check("rst tcount", int'(tcount), 1);
    check("rst wcount", int'(wcount), 0);
    check("rst valid", int'(wcount_valid), 0);
    check("rst empty", int'(empty), 1);
    check("rst full", int'(full), 0);
    check("rst rom_tcount", int'(rom_if.rom_tcount), 1);
    check("rst rom_pcount", int'(rom_if.rom_pcount), 0);
    rst = 1'b0;
    tick(); check("rel e1 valid", int'(wcount_valid), 0);
    tick(); check("rel e2 valid", int'(wcount_valid), 0);
    tick(); check("rel e3 valid", int'(wcount_valid), 1);
    check("rel e3 wcount", int'(wcount), 0);

    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].arg, dropped);
      check_state($sformatf("vec%0d", i), tbl[i].p, tbl[i].t, tbl[i].w);
      if (tbl[i].nochg) check($sformatf("vec%0d no lookup", i), int'(dropped), 0);
    end

    // Entry timing at pcount 1, tcount 1
    front_sensor = 1'b1;
    tick(); check("ent k pcount", int'(pcount), 1);
    tick(); front_sensor = 1'b0;
    check("ent k+1 pcount", int'(pcount), 1);
    check("ent k+1 valid", int'(wcount_valid), 1);
    tick(); check("ent k+2 pcount", int'(pcount), 2);
    check("ent k+2 valid", int'(wcount_valid), 0);
    tick(); tick(); check("ent k+4 valid", int'(wcount_valid), 0);
    tick(); check("ent k+5 valid", int'(wcount_valid), 1);
    check("ent k+5 wcount", int'(wcount), 6);
    repeat (4) tick();

    // Exit lands during CAP of the entry lookup
    front_sensor = 1'b1;
    tick(); tick();
    front_sensor = 1'b0;
    back_sensor = 1'b1;
    tick(); check("mid k+2 pcount", int'(pcount), 3);
    tick(); back_sensor = 1'b0;
    tick(); check("mid k+4 pcount", int'(pcount), 2);
    tick(); check("mid k+5 valid", int'(wcount_valid), 0);
    tick(); tick(); check("mid k+7 valid", int'(wcount_valid), 0);
    tick(); check("mid k+8 valid", int'(wcount_valid), 1);
    check("mid k+8 wcount", int'(wcount), 6);
    repeat (4) tick();

    // Reset asserted while in REQ
    front_sensor = 1'b1;
    tick(); tick();
    front_sensor = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    check("abort pcount", int'(pcount), 0);
    check("abort tcount", int'(tcount), 1);
    check("abort wcount", int'(wcount), 0);
    check("abort valid", int'(wcount_valid), 0);
    check("abort empty", int'(empty), 1);
    check("abort rom_pcount", int'(rom_if.rom_pcount), 0);
    check("abort rom_tcount", int'(rom_if.rom_tcount), 1);
    tick();
    rst = 1'b0;
    tick(); tick(); check("abort e2 valid", int'(wcount_valid), 0);
    tick(); check("abort e3 valid", int'(wcount_valid), 1);
    check("abort e3 wcount", int'(wcount), 0);

    // Randomized operations against the occupancy/teller model
    mp = 0;
    mt = 1;
    for (int n = 0; n < 60; n++) begin
      op  = int'($urandom_range(0, 3));
      arg = int'($urandom_range(0, 3));
      case (op)
        OP_E: if (mp < MAXP) mp++;
        OP_X: if (mp > 0) mp--;
        OP_B: begin
          if (mp == 0) mp = 1;
          else if (mp == MAXP) mp = MAXP - 1;
        end
        default: if (arg != 0) mt = arg;
      endcase
      do_op(op, arg, dropped);
      check_state($sformatf("rnd%0d", n), mp, mt, wait_time(mt, mp));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
